// File: rtl/seq_hex_adder.sv
// Nibble-serial adder/subtractor: one hex digit per clock, then a registered
// commit of S, carryOut and 7-segment patterns. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seq_hex_adder #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          X,
  input  logic [WIDTH-1:0]          Y,
  output logic                      ready,
  output logic                      done,
  output logic [WIDTH-1:0]          S,
  output logic                      carryOut,
  output logic [7*(WIDTH/4)-1:0]    hexOut
);

  localparam int DIGITS = WIDTH / 4;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} stateT;

  stateT                 state;
  logic [WIDTH-1:0]      opA;
  logic [WIDTH-1:0]      opB;
  logic [WIDTH-1:0]      partial;
  logic [WIDTH-1:0]      nextPartial;
  logic [WIDTH+3:0]      shiftedPartial;
  logic                  carry;
  logic [IW-1:0]         idx;
  logic [4:0]            nibSum;
  logic [7*DIGITS-1:0]   nextHex;
  logic [7*DIGITS-1:0]   resetHex;

  function automatic logic [6:0] segOf(input logic [3:0] nib);
    case (nib)
      4'h0: segOf = 7'h40;
      4'h1: segOf = 7'h79;
      4'h2: segOf = 7'h24;
      4'h3: segOf = 7'h30;
      4'h4: segOf = 7'h19;
      4'h5: segOf = 7'h12;
      4'h6: segOf = 7'h02;
      4'h7: segOf = 7'h78;
      4'h8: segOf = 7'h00;
      4'h9: segOf = 7'h10;
      4'hA: segOf = 7'h08;
      4'hB: segOf = 7'h03;
      4'hC: segOf = 7'h46;
      4'hD: segOf = 7'h21;
      4'hE: segOf = 7'h06;
      default: segOf = 7'h0E;
    endcase
  endfunction

  // Operands shift down each cycle so the active digit is always at bit 0;
  // the partial result fills from the top, leaving digit 0 at the bottom after DIGITS shifts.
  always_comb begin
    nibSum         = {1'b0, opA[3:0]} + {1'b0, opB[3:0]} + {4'b0000, carry};
    shiftedPartial = {nibSum[3:0], partial};
    nextPartial    = shiftedPartial[WIDTH+3:4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS:0] nonZeroAbove;
  assign nonZeroAbove[DIGITS] = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gDigit
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is shown if it or any higher digit is nonzero; digit 0 is always shown.
      assign nonZeroAbove[g] = (|nextPartial[4*g +: 4]) | nonZeroAbove[g+1];
      assign nextHex[7*g +: 7] = ((g == 0) || nonZeroAbove[g]) ? segOf(nextPartial[4*g +: 4]) : 7'h7F;
      assign resetHex[7*g +: 7] = (g == 0) ? 7'h40 : 7'h7F;
`else
      assign nextHex[7*g +: 7]  = segOf(nextPartial[4*g +: 4]);
      assign resetHex[7*g +: 7] = 7'h40;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      S        <= '0;
      carryOut <= 1'b0;
      hexOut   <= resetHex;
      opA      <= '0;
      opB      <= '0;
      partial  <= '0;
      carry    <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opA     <= X;
            opB     <= mode ? ~Y : Y;
            carry   <= mode;
            idx     <= '0;
            partial <= '0;
            ready   <= 1'b0;
            state   <= ADD;
          end
        end
        ADD: begin
          opA     <= opA >> 4;
          opB     <= opB >> 4;
          partial <= nextPartial;
          carry   <= nibSum[4];
          idx     <= idx + 1'b1;
          // Visible outputs change only here, so partial sums never reach S or the display.
          if (idx == LAST_IDX) begin
            S        <= nextPartial;
            carryOut <= nibSum[4];
            hexOut   <= nextHex;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_hex_adder.sv
// Scoreboard bench for seq_hex_adder (WIDTH=8 main instance, WIDTH=16 side instance).
module tb_seq_hex_adder;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic        ready;
  logic        done;
  logic [7:0]  S;
  logic        carryOut;
  logic [13:0] hexOut;

  logic        start16 = 1'b0;
  logic        mode16 = 1'b0;
  logic [15:0] X16 = '0;
  logic [15:0] Y16 = '0;
  logic        ready16;
  logic        done16;
  logic [15:0] S16;
  logic        carryOut16;
  logic [27:0] hexOut16;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [7:0] s; logic c;} expT;
  expT sbq[$];
  int  busy = 0;

  seq_hex_adder #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .X(X), .Y(Y),
    .ready(ready), .done(done), .S(S), .carryOut(carryOut), .hexOut(hexOut));

  seq_hex_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .start(start16), .mode(mode16), .X(X16), .Y(Y16),
    .ready(ready16), .done(done16), .S(S16), .carryOut(carryOut16), .hexOut(hexOut16));

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] hexModel(input logic [15:0] v, input int nd);
    logic [27:0] r;
    logic [15:0] t;
    logic        lead;
    logic        show;
    r = '0;
    lead = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      t = v >> (4 * i);
      if (t[3:0] != 4'h0) lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      show = !lead || (i == 0);
`else
      show = 1'b1;
`endif
      r = {r[20:0], (show ? segOf(t[3:0]) : 7'h7F)};
    end
    return r;
  endfunction

  function automatic expT expectOf(input logic [7:0] a, input logic [7:0] b, input logic m);
    expT e;
    if (m) begin
      e.s = a - b;
      e.c = (a >= b);
    end else begin
      e.s = a + b;
      e.c = ({1'b0, a} + {1'b0, b}) > 9'h0FF;
    end
    return e;
  endfunction

  // Independent acceptance model: push expected result on each accept, busy for D+1 edges.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy = 0;
      sbq.delete();
    end else if (busy > 0) begin
      busy--;
    end else if (start) begin
      sbq.push_back(expectOf(X, Y, mode));
      busy = D + 1;
    end
  end

  always @(negedge clk) begin
    expT         e;
    logic [27:0] hm;
    if (resetn) begin
      checks++;
      if (ready !== (busy == 0)) begin
        failures++;
        $display("[TB] FAIL mon_ready got=%b exp=%b", ready, (busy == 0));
      end
      checks++;
      if (done !== (busy == 1)) begin
        failures++;
        $display("[TB] FAIL mon_done got=%b exp=%b", done, (busy == 1));
      end
      if (done === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_empty got=done exp=no_done");
        end else begin
          e = sbq.pop_front();
          hm = hexModel({8'h00, e.s}, D);
          if (S !== e.s || carryOut !== e.c || hexOut !== hm[13:0]) begin
            failures++;
            $display("[TB] FAIL sb_result got=%h/%b/%h exp=%h/%b/%h",
                     S, carryOut, hexOut, e.s, e.c, hm[13:0]);
          end
        end
      end
    end
  end

  task automatic doOp(input logic [7:0] x, input logic [7:0] y, input logic m, output int lat);
    X = x; Y = y; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 20);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [27:0] hm;
    hm = hexModel(16'h0000, D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (S !== 8'h00 || carryOut !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_S got=%h/%b exp=00/0", S, carryOut);
    end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_hs got=%b/%b exp=1/0", ready, done);
    end
    checks++;
    if (hexOut !== hm[13:0]) begin
      failures++; $display("[TB] FAIL reset_hex got=%h exp=%h", hexOut, hm[13:0]);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    doOp(8'h3A, 8'h25, 1'b0, lat);
    checks++;
    if (lat !== D + 1) begin
      failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, D + 1);
    end
    checks++;
    if (S !== 8'h5F || carryOut !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_sum got=%h/%b exp=5f/0", S, carryOut);
    end
    checks++;
    if (hexOut[13:7] !== 7'h12 || hexOut[6:0] !== 7'h0E) begin
      failures++; $display("[TB] FAIL basic_hex got=%h exp=%h", hexOut, {7'h12, 7'h0E});
    end
  endtask

  task automatic test_wrap;
    logic [13:0] prevHex;
    int          cyc;
    prevHex = hexOut;
    X = 8'hFF; Y = 8'h01; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1 || cyc >= 20) break;
      checks++;
      if (S !== 8'h5F || hexOut !== prevHex) begin
        failures++; $display("[TB] FAIL wrap_hold got=%h/%h exp=5f/%h", S, hexOut, prevHex);
      end
    end
    checks++;
    if (done !== 1'b1 || S !== 8'h00 || carryOut !== 1'b1) begin
      failures++; $display("[TB] FAIL wrap_sum got=%b/%h/%b exp=1/00/1", done, S, carryOut);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    int lat;
    doOp(8'h10, 8'h01, 1'b1, lat);
    checks++;
    if (S !== 8'h0F || carryOut !== 1'b1) begin
      failures++; $display("[TB] FAIL sub_noborrow got=%h/%b exp=0f/1", S, carryOut);
    end
    doOp(8'h01, 8'h02, 1'b1, lat);
    checks++;
    if (S !== 8'hFF || carryOut !== 1'b0) begin
      failures++; $display("[TB] FAIL sub_borrow got=%h/%b exp=ff/0", S, carryOut);
    end
  endtask

  task automatic test_back_to_back;
    int doneCount;
    int waitCyc;
    doneCount = 0;
    X = 8'($urandom); Y = 8'($urandom); mode = 1'($urandom); start = 1'b1;
    for (int i = 0; i < 3 * (D + 2); i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
      @(posedge clk); #1;
      X = 8'($urandom); Y = 8'($urandom); mode = 1'($urandom);
    end
    start = 1'b0;
    checks++;
    if (doneCount !== 3) begin
      failures++; $display("[TB] FAIL b2b_done_count got=%0d exp=3", doneCount);
    end
    waitCyc = 0;
    while (sbq.size() != 0 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("[TB] FAIL b2b_drain got=%0d exp=0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic [27:0] hm;
    hm = hexModel(16'h0000, D);
    doOp(8'h3A, 8'h25, 1'b0, lat);
    X = 8'h12; Y = 8'h34; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (S !== 8'h00 || carryOut !== 1'b0 || hexOut !== hm[13:0]) begin
      failures++; $display("[TB] FAIL midreset_out got=%h/%b/%h exp=00/0/%h", S, carryOut, hexOut, hm[13:0]);
    end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_hs got=%b/%b exp=1/0", ready, done);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("[TB] FAIL midreset_nodone got=%b exp=0", done);
      end
    end
    @(posedge clk); #1;
    doOp(8'h12, 8'h34, 1'b0, lat);
    checks++;
    if (lat !== D + 1 || S !== 8'h46 || carryOut !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_next got=%0d/%h/%b exp=3/46/0", lat, S, carryOut);
    end
  endtask

  task automatic test_blank;
    int         lat;
    logic [6:0] expHi;
`ifdef LEADING_ZERO_BLANK_EN
    expHi = 7'h7F;
`else
    expHi = 7'h40;
`endif
    doOp(8'h02, 8'h03, 1'b0, lat);
    checks++;
    if (S !== 8'h05 || hexOut[6:0] !== 7'h12 || hexOut[13:7] !== expHi) begin
      failures++; $display("[TB] FAIL blank got=%h/%h exp=05/%h", S, hexOut, {expHi, 7'h12});
    end
  endtask

  task automatic doOp16(input logic [15:0] x, input logic [15:0] y, input logic m, output int lat);
    X16 = x; Y16 = y; mode16 = m; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done16 !== 1'b1 && lat < 30);
  endtask

  task automatic test_width16;
    int          lat;
    logic [27:0] hm;
    doOp16(16'h1234, 16'h0FFF, 1'b0, lat);
    hm = hexModel(16'h2233, 4);
    checks++;
    if (lat !== 5) begin
      failures++; $display("[TB] FAIL w16_latency got=%0d exp=5", lat);
    end
    checks++;
    if (S16 !== 16'h2233 || carryOut16 !== 1'b0 || hexOut16 !== hm) begin
      failures++; $display("[TB] FAIL w16_sum got=%h/%b/%h exp=2233/0/%h", S16, carryOut16, hexOut16, hm);
    end
    @(posedge clk); #1;
    doOp16(16'h0005, 16'h0003, 1'b0, lat);
    hm = hexModel(16'h0008, 4);
    checks++;
    if (S16 !== 16'h0008 || carryOut16 !== 1'b0 || hexOut16 !== hm) begin
      failures++; $display("[TB] FAIL w16_small got=%h/%b/%h exp=0008/0/%h", S16, carryOut16, hexOut16, hm);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    test_width16();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
